// File: rtl/eth_tx_desc_queue.sv
// AXI single-beat write slave that steers descriptors into per-channel FIFOs and drains them round-robin.
// Optional ETH_TX_DROP_CNT_EN adds per-channel saturating counters of rejected writes (drop_cnt).
module eth_tx_desc_queue #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CH_LSB = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [DATA_W-1:0] desc_data,
  output logic [CH_W-1:0]   desc_chan,
  output logic [NUM_CH-1:0] ch_full
`ifdef ETH_TX_DROP_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] drop_cnt
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned HI_LSB = CH_LSB + CH_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_RESP   = 2'd2
  } wr_state_e;

  wr_state_e         r_state, w_state_nxt;
  logic              r_aw_got, r_w_got, w_aw_got_nxt, w_w_got_nxt;
  logic              r_awready, r_wready, w_awready_nxt, w_wready_nxt;
  logic              r_bvalid, w_bvalid_nxt;
  logic [1:0]        r_bresp, w_bresp_nxt;
  logic [ADDR_W-1:0] r_awaddr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic              w_aw_hs, w_w_hs;

  logic [CH_W-1:0]   w_ch, w_ch_safe;
  logic              w_hi_zero, w_ch_ok, w_addr_ok, w_has_room, w_push;

  logic [DATA_W-1:0] r_mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  r_count  [NUM_CH];
  logic [CNT_W-1:0]  w_count_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_push_vec, w_pop_vec;
  logic [NUM_CH-1:0] r_ch_full;

  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   w_arb_idx, w_pick_ch;
  logic              w_pick_found, w_load, w_pop;
  logic [DATA_W-1:0] w_pop_data;
  logic              r_desc_valid;
  logic [DATA_W-1:0] r_desc_data;
  logic [CH_W-1:0]   r_desc_chan;

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;

  // Channel decode of the captured address; full is judged on the start-of-cycle count
  assign w_ch       = r_awaddr_q[CH_LSB +: CH_W];
  assign w_hi_zero  = ((r_awaddr_q >> HI_LSB) == '0);
  assign w_ch_ok    = (32'(w_ch) < NUM_CH);
  assign w_addr_ok  = w_hi_zero & w_ch_ok;
  assign w_ch_safe  = w_ch_ok ? w_ch : '0;
  assign w_has_room = (r_count[w_ch_safe] < CNT_W'(DEPTH));
  assign w_push     = (r_state == S_COMMIT) & w_addr_ok & w_has_room;

  // Write FSM: state register and captured AW/W
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_awaddr_q <= '0;
      r_wdata_q  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_got  <= w_aw_got_nxt;
      r_w_got   <= w_w_got_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_aw_hs) r_awaddr_q <= awaddr;
      if (w_w_hs)  r_wdata_q  <= wdata;
    end
  end

  // Write FSM: next state; ready flags are precomputed so they leave a register
  always_comb begin
    w_state_nxt  = r_state;
    w_aw_got_nxt = r_aw_got;
    w_w_got_nxt  = r_w_got;
    w_bvalid_nxt = r_bvalid;
    w_bresp_nxt  = r_bresp;
    unique case (r_state)
      S_IDLE: begin
        if (w_aw_hs) w_aw_got_nxt = 1'b1;
        if (w_w_hs)  w_w_got_nxt  = 1'b1;
        if (w_aw_got_nxt && w_w_got_nxt) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt  = S_RESP;
        w_aw_got_nxt = 1'b0;
        w_w_got_nxt  = 1'b0;
        w_bvalid_nxt = 1'b1;
        w_bresp_nxt  = w_push ? 2'b00 : 2'b10;
      end
      S_RESP: begin
        if (bready) begin
          w_state_nxt  = S_IDLE;
          w_bvalid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_awready_nxt = (w_state_nxt == S_IDLE) && !w_aw_got_nxt;
    w_wready_nxt  = (w_state_nxt == S_IDLE) && !w_w_got_nxt;
  end

  // Round-robin pick: first non-empty channel at or after r_rr
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_ch    = '0;
    w_arb_idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_arb_idx = CH_W'((32'(r_rr) + i) % NUM_CH);
      if (!w_pick_found && (r_count[w_arb_idx] != '0)) begin
        w_pick_found = 1'b1;
        w_pick_ch    = w_arb_idx;
      end
    end
  end

  assign w_load     = !r_desc_valid | desc_ready;
  assign w_pop      = w_load & w_pick_found;
  assign w_pop_data = r_mem[w_pick_ch][r_rd_ptr[w_pick_ch]];

  always_comb begin
    w_push_vec = '0;
    w_pop_vec  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_push_vec[c] = w_push && (w_ch_safe == CH_W'(c));
      w_pop_vec[c]  = w_pop && (w_pick_ch == CH_W'(c));
      unique case ({w_push_vec[c], w_pop_vec[c]})
        2'b10:   w_count_nxt[c] = r_count[c] + CNT_W'(1);
        2'b01:   w_count_nxt[c] = r_count[c] - CNT_W'(1);
        default: w_count_nxt[c] = r_count[c];
      endcase
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_ch_full <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_count[c]   <= w_count_nxt[c];
        r_ch_full[c] <= (w_count_nxt[c] == CNT_W'(DEPTH));
        if (w_push_vec[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
        if (w_pop_vec[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[w_ch_safe][r_wr_ptr[w_ch_safe]] <= r_wdata_q;
  end

  // Single-slot output stage; holds while desc_valid && !desc_ready
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_desc_valid <= 1'b0;
      r_desc_data  <= '0;
      r_desc_chan  <= '0;
      r_rr         <= '0;
    end else if (w_load) begin
      r_desc_valid <= w_pick_found;
      if (w_pick_found) begin
        r_desc_data <= w_pop_data;
        r_desc_chan <= w_pick_ch;
        r_rr        <= (w_pick_ch == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(w_pick_ch + CH_W'(1));
      end
    end
  end

`ifdef ETH_TX_DROP_CNT_EN
  logic [15:0] r_drop [NUM_CH];

  // Rejections caused by a full FIFO on a valid channel only
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned c = 0; c < NUM_CH; c++) r_drop[c] <= '0;
    end else if ((r_state == S_COMMIT) && w_addr_ok && !w_has_room &&
                 (r_drop[w_ch_safe] != 16'hFFFF)) begin
      r_drop[w_ch_safe] <= r_drop[w_ch_safe] + 16'd1;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) drop_cnt[c*16 +: 16] = r_drop[c];
  end
`endif

  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bvalid     = r_bvalid;
  assign bresp      = r_bresp;
  assign desc_valid = r_desc_valid;
  assign desc_data  = r_desc_data;
  assign desc_chan  = r_desc_chan;
  assign ch_full    = r_ch_full;

endmodule
